// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start/soft-stop duty sequencer: owns the PWM period timebase and ramps duty_cmd toward each
// accepted target in STEP increments every RAMP_DIV periods; duty only moves on period boundaries.
module pwm_duty_ramp_ctrl #(
  parameter int PERIOD   = 512,
  parameter int STEP     = 1,
  parameter int RAMP_DIV = 4
) (
  input  logic       clk_main,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] target_duty,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [6:0] duty_cmd,
  output logic       period_tick,
  output logic       busy,
  output logic       done
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    tgt_q, tgt_d;
  logic [6:0]    duty_q, duty_d;
  logic          done_q, done_d;

  logic          run;
  logic          cnt_wrap;
  logic          step_tick;
  logic          accept;
  logic [6:0]    tgt_in;
  logic [6:0]    duty_step;

  // One ramp step from cur toward tgt; snaps onto tgt when within STEP so it never overshoots.
  function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
    logic [7:0] c;
    logic [7:0] t;
    logic [7:0] s;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = 8'(STEP);
    if (t >= c) begin
      step_toward = ((t - c) <= s) ? tgt : 7'(c + s);
    end else begin
      step_toward = ((c - t) <= s) ? tgt : 7'(c - s);
    end
  endfunction

  assign target_ready = enable && ((state_q == IDLE) || (state_q == HOLD));
  assign busy         = (state_q == RAMP) || (state_q == STOP);
  assign duty_cmd     = duty_q;
  assign period_tick  = tick_q;
  assign done         = done_q;

  always_comb begin
    run       = (state_q != IDLE) || enable;
    cnt_wrap  = (cnt_q == CW'(PERIOD - 1));
    cnt_d     = run ? (cnt_wrap ? '0 : cnt_q + 1'b1) : '0;
    // Registered tick mirrors the counter value so it is high exactly while cnt_q == PERIOD-1.
    tick_d    = (cnt_d == CW'(PERIOD - 1));
    step_tick = tick_q && (div_q == DW'(RAMP_DIV - 1));
    accept    = target_valid && target_ready;
    tgt_in    = (target_duty > 7'd100) ? 7'd100 : target_duty;
    duty_step = step_toward(duty_q, tgt_q);
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    div_d   = div_q;
    if (tick_q) begin
      div_d = (div_q == DW'(RAMP_DIV - 1)) ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        duty_d = 7'd0;
        if (accept) begin
          tgt_d = tgt_in;
          div_d = '0;
          if (tgt_in == 7'd0) begin
            state_d = HOLD;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        // The step lands first; the transition then looks at the stepped duty.
        if (step_tick) begin
          duty_d = duty_step;
        end
        if (!enable) begin
          state_d = STOP;
          tgt_d   = 7'd0;
          div_d   = '0;
        end else if (step_tick && (duty_step == tgt_q)) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        if (!enable) begin
          state_d = STOP;
          tgt_d   = 7'd0;
          div_d   = '0;
        end else if (accept) begin
          tgt_d = tgt_in;
          div_d = '0;
          if (tgt_in == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      STOP: begin
        tgt_d = 7'd0;
        if (step_tick) begin
          duty_d = duty_step;
          if (duty_step == 7'd0) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = 7'd0;
        tgt_d   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      div_q   <= '0;
      tgt_q   <= 7'd0;
      duty_q  <= 7'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with PERIOD=8, STEP=10, RAMP_DIV=2.
// k counts rising edges from the first accept; samples are taken on the falling edge after edge k.
module tb_pwm_duty_ramp_ctrl;

  logic       clk_main;
  logic       rst_n;
  logic       enable;
  logic [6:0] target_duty;
  logic       target_valid;
  logic       target_ready;
  logic [6:0] duty_cmd;
  logic       period_tick;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = -100;
  int done_cnt = 0;
  int tick_cnt = 0;
  int d0;
  int t0;
  logic [6:0] prev_duty = 7'd0;
  logic       prev_tick = 1'b0;
  logic       prev_rst  = 1'b0;

  pwm_duty_ramp_ctrl #(
    .PERIOD  (8),
    .STEP    (10),
    .RAMP_DIV(2)
  ) dut (
    .clk_main    (clk_main),
    .rst_n       (rst_n),
    .enable      (enable),
    .target_duty (target_duty),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .duty_cmd    (duty_cmd),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk_main = 1'b0;
    forever #5 clk_main = ~clk_main;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic adv();
    @(negedge clk_main);
    k++;
  endtask

  task automatic goto(input int n);
    while (k < n) adv();
  endtask

  // Duty may only move on the edge that closes a period_tick cycle (reset excepted).
  always @(negedge clk_main) begin
    if (rst_n && prev_rst && (duty_cmd != prev_duty)) chk("duty_moves_on_tick", int'(prev_tick), 1);
    if (rst_n && done) done_cnt++;
    if (rst_n && period_tick) tick_cnt++;
    prev_duty = duty_cmd;
    prev_tick = period_tick;
    prev_rst  = rst_n;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    target_valid = 1'b0;
    target_duty = 7'd0;
    repeat (3) @(negedge clk_main);
    chk("rst_duty", duty_cmd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", target_ready, 0);
    chk("rst_tick", period_tick, 0);
    rst_n = 1'b1;
    @(negedge clk_main);
    k = -1;

    // Ramp 0 -> 30, with an offer of 80 during the ramp that must be ignored.
    enable = 1'b1;
    target_valid = 1'b1;
    target_duty = 7'd30;
    adv();
    chk("t1_busy", busy, 1);
    chk("t1_ready_ramp", target_ready, 0);
    target_valid = 1'b0;
    goto(5);
    chk("t1_tick_k5", period_tick, 0);
    target_valid = 1'b1;
    target_duty = 7'd80;
    goto(6);
    chk("t1_tick_k6", period_tick, 1);
    goto(10);
    chk("t3_ready_ramp", target_ready, 0);
    goto(14);
    chk("t1_duty_k14", duty_cmd, 0);
    goto(15);
    chk("t1_duty_k15", duty_cmd, 10);
    goto(20);
    target_valid = 1'b0;
    goto(31);
    chk("t1_duty_k31", duty_cmd, 20);
    goto(46);
    chk("t1_duty_k46", duty_cmd, 20);
    chk("t1_busy_k46", busy, 1);
    chk("t1_done_k46", done, 0);
    goto(47);
    chk("t1_duty_k47", duty_cmd, 30);
    chk("t1_done_k47", done, 1);
    chk("t1_busy_k47", busy, 0);
    chk("t1_ready_hold", target_ready, 1);
    goto(48);
    chk("t1_done_k48", done, 0);

    // HOLD 30 -> 25 snaps in one step; then back to 30; then an equal target.
    goto(50);
    target_duty = 7'd25;
    target_valid = 1'b1;
    goto(51);
    chk("t2_busy", busy, 1);
    target_valid = 1'b0;
    goto(62);
    chk("t2_duty_k62", duty_cmd, 30);
    goto(63);
    chk("t2_duty_k63", duty_cmd, 25);
    chk("t2_done_k63", done, 1);
    goto(66);
    target_duty = 7'd30;
    target_valid = 1'b1;
    goto(67);
    target_valid = 1'b0;
    goto(79);
    chk("t2_duty_k79", duty_cmd, 30);
    chk("t2_done_k79", done, 1);
    goto(82);
    target_valid = 1'b1;
    goto(83);
    chk("t2_eq_done", done, 1);
    chk("t2_eq_busy", busy, 0);
    target_valid = 1'b0;

    // Soft stop from 30.
    goto(86);
    d0 = done_cnt;
    enable = 1'b0;
    goto(87);
    chk("t4_busy", busy, 1);
    chk("t4_ready", target_ready, 0);
    goto(102);
    chk("t4_duty_k102", duty_cmd, 30);
    goto(103);
    chk("t4_duty_k103", duty_cmd, 20);
    goto(119);
    chk("t4_duty_k119", duty_cmd, 10);
    goto(134);
    chk("t4_busy_k134", busy, 1);
    goto(135);
    chk("t4_duty_k135", duty_cmd, 0);
    chk("t4_busy_k135", busy, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    t0 = tick_cnt;
    goto(150);
    chk("t4_no_ticks_idle", tick_cnt - t0, 0);
    chk("t4_ready_idle", target_ready, 0);

    // Target 0 from IDLE goes straight to HOLD with one done pulse.
    enable = 1'b1;
    target_duty = 7'd0;
    target_valid = 1'b1;
    d0 = done_cnt;
    goto(151);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    chk("t6_ready", target_ready, 1);
    chk("t6_duty", duty_cmd, 0);
    target_valid = 1'b0;
    goto(154);
    chk("t6_single_done", done_cnt - d0, 1);

    // 150 clamps to 100; ramp up, then async reset at duty 20.
    target_duty = 7'd150;
    target_valid = 1'b1;
    goto(155);
    chk("t2c_busy", busy, 1);
    target_valid = 1'b0;
    goto(157);
    chk("t2c_tick_k157", period_tick, 1);
    goto(165);
    chk("t2c_duty_k165", duty_cmd, 0);
    goto(166);
    chk("t2c_duty_k166", duty_cmd, 10);
    goto(182);
    chk("t2c_duty_k182", duty_cmd, 20);
    goto(186);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("t5_duty_async", duty_cmd, 0);
    chk("t5_busy_async", busy, 0);
    adv();
    adv();
    rst_n = 1'b1;
    adv();
    chk("t5_ready_released", target_ready, 0);
    chk("t5_duty_released", duty_cmd, 0);
    chk("t5_tick_released", period_tick, 0);
    enable = 1'b1;
    #1;
    chk("t5_ready_enabled", target_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
